// File: rtl/menu_text_mux.sv
// Frame-synchronous text-source selector for the menu overlay: picks one of
// CHANNELS code streams, optionally blink-masks it, and delays code and font line together.
module menu_text_mux #(
  parameter int               CHANNELS     = 4,
  parameter int               CODE_W       = 7,
  parameter int               LINE_W       = 4,
  parameter int               LATENCY      = 1,
  parameter int               BLINK_FRAMES = 30,
  parameter logic [CODE_W-1:0] BLANK_CODE  = 7'h20,
  parameter int               SEL_W        = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL_W-1:0]           select,
  input  logic                       select_valid,
  input  logic                       frame_start,
  input  logic                       blink_en,
  input  logic [CHANNELS*CODE_W-1:0] char_codes_in,
  input  logic [LINE_W-1:0]          char_line_in,
  output logic [CODE_W-1:0]          char_code,
  output logic [LINE_W-1:0]          char_line_out,
  output logic [SEL_W-1:0]           active_sel,
  output logic                       switch_pending
);

  localparam int                 CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [SEL_W:0]     CH_LIM   = (SEL_W + 1)'(CHANNELS);
  localparam int                 SLOTS    = 2 ** SEL_W;

  logic [SEL_W-1:0] req_reg, req_next;
  logic             pending_reg, pending_next;
  logic [SEL_W-1:0] active_sel_reg, active_sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             phase_reg, phase_next;

  logic accept;
  logic apply;

  assign accept = select_valid && ({1'b0, select} < CH_LIM);
  assign apply  = frame_start && pending_reg;

  // Apply uses the request held before this cycle; a same-cycle request queues for the next frame.
  always_comb begin
    req_next        = req_reg;
    pending_next    = pending_reg;
    active_sel_next = active_sel_reg;
    cnt_next        = cnt_reg;
    phase_next      = phase_reg;
    if (apply) begin
      active_sel_next = req_reg;
      pending_next    = 1'b0;
    end
    if (accept) begin
      req_next     = select;
      pending_next = 1'b1;
    end
    if (apply) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (frame_start) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next   = '0;
        phase_next = ~phase_reg;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_reg        <= '0;
      pending_reg    <= 1'b0;
      active_sel_reg <= '0;
      cnt_reg        <= '0;
      phase_reg      <= 1'b0;
    end else begin
      req_reg        <= req_next;
      pending_reg    <= pending_next;
      active_sel_reg <= active_sel_next;
      cnt_reg        <= cnt_next;
      phase_reg      <= phase_next;
    end
  end

  // Channel table padded to a power of two so every select value indexes a real entry.
  logic [CODE_W-1:0] chan_code [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_chan
      if (gi < CHANNELS) begin : g_used
        assign chan_code[gi] = char_codes_in[gi*CODE_W +: CODE_W];
      end else begin : g_pad
        assign chan_code[gi] = '0;
      end
    end
  endgenerate

  logic [CODE_W-1:0] stage0_code;
  assign stage0_code = (blink_en && phase_reg) ? BLANK_CODE : chan_code[active_sel_reg];

  logic [CODE_W-1:0] code_pipe_reg [LATENCY];
  logic [LINE_W-1:0] line_pipe_reg [LATENCY];

  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            code_pipe_reg[gi] <= '0;
            line_pipe_reg[gi] <= '0;
          end else begin
            code_pipe_reg[gi] <= stage0_code;
            line_pipe_reg[gi] <= char_line_in;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            code_pipe_reg[gi] <= '0;
            line_pipe_reg[gi] <= '0;
          end else begin
            code_pipe_reg[gi] <= code_pipe_reg[gi-1];
            line_pipe_reg[gi] <= line_pipe_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign char_code      = code_pipe_reg[LATENCY-1];
  assign char_line_out  = line_pipe_reg[LATENCY-1];
  assign active_sel     = active_sel_reg;
  assign switch_pending = pending_reg;

endmodule
